// File: rtl/alu_cmd_sequencer_if.sv
// Valid/ready links of the ALU command sequencer: the byte-serial command
// stream going in and the captured result coming out.
interface alu_cmd_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] res_data;
  logic [1:0] res_op;
  logic       res_valid;
  logic       res_ready;

  // Environment side: sends command bytes, consumes results.
  modport master (
    output in_data, in_valid, res_ready,
    input  in_ready, res_data, res_op, res_valid
  );

  // Sequencer side: consumes command bytes, produces results.
  modport slave (
    input  in_data, in_valid, res_ready,
    output in_ready, res_data, res_op, res_valid
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: collects header/A/B bytes, drives the external
// 4-function ALU, waits the settle time, captures the result and hands it
// downstream. No arithmetic is done here; the ALU value is passed as-is.
module alu_cmd_sequencer #(
  parameter logic [3:0]  SYNC_NIBBLE = 4'hA,
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [1:0]          alu_s,
  input  logic [7:0]          alu_out,
  output logic                busy,
  output logic [COUNT_W-1:0]  op_count,
  output logic [7:0]          err_count
);

  // A zero settle time would make the down-counter wrap; treat it as one.
  localparam int unsigned EXEC_LOAD = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int unsigned CNT_W     = (EXEC_LOAD < 2) ? 1 : $clog2(EXEC_LOAD + 1);

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_GET_A = 3'd1,
    ST_GET_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  state_e             state_q,     state_d;
  logic [7:0]         alu_a_q,     alu_a_d;
  logic [7:0]         alu_b_q,     alu_b_d;
  logic [1:0]         alu_s_q,     alu_s_d;
  logic [7:0]         res_data_q,  res_data_d;
  logic [1:0]         res_op_q,    res_op_d;
  logic               res_valid_q, res_valid_d;
  logic [COUNT_W-1:0] op_count_q,  op_count_d;
  logic [7:0]         err_count_q, err_count_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;

  logic in_ready_s;
  logic in_xfer_s;
  logic res_xfer_s;

  // Bytes are accepted only while collecting a command; depends on state alone.
  assign in_ready_s = (state_q == ST_HDR) || (state_q == ST_GET_A) || (state_q == ST_GET_B);
  assign in_xfer_s  = bus.in_valid && in_ready_s;
  assign res_xfer_s = res_valid_q && bus.res_ready;

  // Next-state and next-output computation for the command sequencer.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_HDR: begin
        if (in_xfer_s) begin
          if (bus.in_data[7:4] == SYNC_NIBBLE) begin
            // Bits [3:2] of the header are reserved and ignored.
            alu_s_d = bus.in_data[1:0];
            state_d = ST_GET_A;
          end else if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end else begin
            err_count_d = err_count_q;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_GET_A: begin
        if (in_xfer_s) begin
          alu_a_d = bus.in_data;
          state_d = ST_GET_B;
        end else begin
          state_d = ST_GET_A;
        end
      end
      ST_GET_B: begin
        if (in_xfer_s) begin
          alu_b_d = bus.in_data;
          cnt_d   = CNT_W'(EXEC_LOAD);
          state_d = ST_EXEC;
        end else begin
          state_d = ST_GET_B;
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          res_data_d  = alu_out;
          res_op_d    = alu_s_q;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (res_xfer_s) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + COUNT_W'(1);
          state_d     = ST_HDR;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_HDR;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HDR;
      alu_a_q     <= 8'd0;
      alu_b_q     <= 8'd0;
      alu_s_q     <= 2'd0;
      res_data_q  <= 8'd0;
      res_op_q    <= 2'd0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
      err_count_q <= 8'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.res_data  = res_data_q;
  assign bus.res_op    = res_op_q;
  assign bus.res_valid = res_valid_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_s         = alu_s_q;
  assign busy          = (state_q != ST_HDR);
  assign op_count      = op_count_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: one instance with EXEC_CYCLES=1 for
// the functional tests and one with EXEC_CYCLES=4 for the settle-time test.
// A behavioural model of the 4-function ALU closes the loop.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [7:0] in_data;
  logic in_valid, res_ready;
  logic use4;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_ops;

  alu_cmd_sequencer_if ifa ();
  alu_cmd_sequencer_if ifb ();

  logic [7:0] alu_a_a, alu_b_a, alu_out_a, err_a;
  logic [1:0] alu_s_a;
  logic       busy_a;
  logic [15:0] opc_a;
  logic [7:0] alu_a_b, alu_b_b, alu_out_b, err_b;
  logic [1:0] alu_s_b;
  logic       busy_b;
  logic [15:0] opc_b;

  assign ifa.in_data   = in_data;
  assign ifa.in_valid  = in_valid;
  assign ifa.res_ready = res_ready;
  assign ifb.in_data   = in_data;
  assign ifb.in_valid  = in_valid;
  assign ifb.res_ready = res_ready;

  alu_cmd_sequencer #(.SYNC_NIBBLE(4'hA), .EXEC_CYCLES(1), .COUNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave),
    .alu_a(alu_a_a), .alu_b(alu_b_a), .alu_s(alu_s_a), .alu_out(alu_out_a),
    .busy(busy_a), .op_count(opc_a), .err_count(err_a)
  );

  alu_cmd_sequencer #(.SYNC_NIBBLE(4'hA), .EXEC_CYCLES(4), .COUNT_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave),
    .alu_a(alu_a_b), .alu_b(alu_b_b), .alu_s(alu_s_b), .alu_out(alu_out_b),
    .busy(busy_b), .op_count(opc_b), .err_count(err_b)
  );

  // Reference 4-function ALU.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    logic [7:0] bs;
    logic signed [9:0] sa, sb, t;
    bs = $signed(b) >>> 2;
    sa = $signed(a);
    sb = $signed(b);
    t  = sa * 10'sd3 - sb;
    case (s)
      2'd0:    alu_f = (a <<< 2) + bs;
      2'd1:    alu_f = a + (b << 1);
      2'd2:    alu_f = 8'd0 - b;
      2'd3:    alu_f = (t < 10'sd0) ? 8'(10'sd0 - t) : t[7:0];
      default: alu_f = 8'd0;
    endcase
  endfunction

  assign alu_out_a = alu_f(alu_a_a, alu_b_a, alu_s_a);
  assign alu_out_b = alu_f(alu_a_b, alu_b_b, alu_s_b);

  // Views of whichever instance is currently under test.
  logic       cur_ready, cur_rv, cur_busy;
  logic [7:0] cur_rd, cur_err;
  logic [1:0] cur_op;
  logic [15:0] cur_opc;
  assign cur_ready = use4 ? ifb.in_ready  : ifa.in_ready;
  assign cur_rv    = use4 ? ifb.res_valid : ifa.res_valid;
  assign cur_rd    = use4 ? ifb.res_data  : ifa.res_data;
  assign cur_op    = use4 ? ifb.res_op    : ifa.res_op;
  assign cur_busy  = use4 ? busy_b        : busy_a;
  assign cur_err   = use4 ? err_b         : err_a;
  assign cur_opc   = use4 ? opc_b         : opc_a;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and wait (bounded) for it to be accepted.
  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!cur_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cur_ready) check_eq("push_ready", 32'(cur_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for res_valid.
  task automatic wait_res();
    int n;
    n = 0;
    while (!cur_rv && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("res_valid_rise", 32'(cur_rv), 32'd1);
  endtask

  // Full command with immediate handoff; checks result, op and op_count.
  task automatic run_cmd(input string tag, input logic [7:0] h, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_d, input logic [1:0] exp_o);
    push(h);
    push(a);
    push(b);
    in_valid = 1'b0;
    wait_res();
    check_eq({tag, "_data"}, 32'(cur_rd), 32'(exp_d));
    check_eq({tag, "_op"}, 32'(cur_op), 32'(exp_o));
    @(posedge clk); #1;
    exp_ops++;
    check_eq({tag, "_opcount"}, 32'(cur_opc), 32'(exp_ops));
    check_eq({tag, "_idle"}, 32'(cur_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    use4      = 1'b0;
    rst_a     = 1'b1;
    rst_b     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    exp_ops   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;

    // Reset state
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_res_valid", 32'(ifa.res_valid), 32'd0);
    check_eq("rst_res_data", 32'(ifa.res_data), 32'd0);
    check_eq("rst_opcount", 32'(opc_a), 32'd0);
    check_eq("rst_errcount", 32'(err_a), 32'd0);
    check_eq("rst_in_ready", 32'(ifa.in_ready), 32'd1);

    // Basic op 1 with exact latency
    push(8'hA1);
    push(8'h10);
    push(8'h08);
    in_valid = 1'b0;
    check_eq("basic_rv_early", 32'(cur_rv), 32'd0);
    check_eq("basic_in_ready_exec", 32'(cur_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("basic_rv", 32'(cur_rv), 32'd1);
    check_eq("basic_data", 32'(cur_rd), 32'h20);
    check_eq("basic_op", 32'(cur_op), 32'd1);
    @(posedge clk); #1;
    exp_ops++;
    check_eq("basic_opcount", 32'(cur_opc), 32'(exp_ops));
    check_eq("basic_busy", 32'(cur_busy), 32'd0);
    check_eq("basic_rv_drop", 32'(cur_rv), 32'd0);

    // All ops
    run_cmd("op0", 8'hA0, 8'h05, 8'h10, 8'h18, 2'd0);
    run_cmd("op2", 8'hA2, 8'h33, 8'h01, 8'hFF, 2'd2);
    run_cmd("op3", 8'hA3, 8'h02, 8'h0A, 8'h04, 2'd3);
    run_cmd("op0_rsvd", 8'hAC, 8'h01, 8'h01, 8'h04, 2'd0);

    // Bad header
    push(8'h31);
    in_valid = 1'b0;
    check_eq("bad_err", 32'(cur_err), 32'd1);
    check_eq("bad_busy", 32'(cur_busy), 32'd0);
    run_cmd("after_bad", 8'hA1, 8'h01, 8'h01, 8'h03, 2'd1);

    // Backpressure: 2 + 2*3 = 8
    push(8'hA1);
    push(8'h02);
    push(8'h03);
    in_data   = 8'hA2;
    in_valid  = 1'b1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_data", 32'(cur_rd), 32'h08);
      check_eq("bp_op", 32'(cur_op), 32'd1);
      check_eq("bp_in_ready", 32'(cur_ready), 32'd0);
      check_eq("bp_rv", 32'(cur_rv), 32'd1);
      check_eq("bp_err", 32'(cur_err), 32'd1);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    exp_ops++;
    check_eq("bp_handoff_busy", 32'(cur_busy), 32'd0);
    check_eq("bp_handoff_ready", 32'(cur_ready), 32'd1);
    check_eq("bp_opcount", 32'(cur_opc), 32'(exp_ops));
    @(posedge clk); #1;
    check_eq("bp_hdr_taken", 32'(cur_busy), 32'd1);
    check_eq("bp_hdr_sel", 32'(alu_s_a), 32'd2);
    push(8'h00);
    push(8'h05);
    in_valid = 1'b0;
    wait_res();
    check_eq("bp_next_data", 32'(cur_rd), 32'hFB);
    @(posedge clk); #1;
    exp_ops++;

    // Reset mid-command
    push(8'hA1);
    push(8'h55);
    in_valid = 1'b0;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    exp_ops = 0;
    check_eq("mid_rst_busy", 32'(cur_busy), 32'd0);
    check_eq("mid_rst_alu_a", 32'(alu_a_a), 32'd0);
    check_eq("mid_rst_opcount", 32'(cur_opc), 32'd0);
    check_eq("mid_rst_err", 32'(cur_err), 32'd0);
    check_eq("mid_rst_rv", 32'(cur_rv), 32'd0);
    run_cmd("after_rst", 8'hA2, 8'h00, 8'h05, 8'hFB, 2'd2);

    // Error counter saturation
    in_data  = 8'h31;
    in_valid = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("err_sat", 32'(cur_err), 32'd255);

    // Settle time with EXEC_CYCLES=4
    rst_a = 1'b1;
    use4  = 1'b1;
    @(posedge clk); #1;
    rst_b   = 1'b0;
    exp_ops = 0;
    push(8'hA1);
    push(8'h10);
    push(8'h08);
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check_eq("e4_rv_low", 32'(cur_rv), 32'd0);
      check_eq("e4_alu_a", 32'(alu_a_b), 32'h10);
      check_eq("e4_alu_b", 32'(alu_b_b), 32'h08);
      check_eq("e4_alu_s", 32'(alu_s_b), 32'd1);
    end
    @(posedge clk); #1;
    check_eq("e4_rv", 32'(cur_rv), 32'd1);
    check_eq("e4_data", 32'(cur_rd), 32'h20);
    check_eq("e4_op", 32'(cur_op), 32'd1);
    @(posedge clk); #1;
    exp_ops++;
    check_eq("e4_opcount", 32'(cur_opc), 32'(exp_ops));
    check_eq("e4_idle", 32'(cur_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
